// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: runs one command through a UART wrapper
// (clear, load, send, wait) and returns the captured response word.
module uart_cmd_sequencer #(
    parameter int TX_WIDTH = 32,
    parameter int RX_WIDTH = 32,
    parameter int TIMEOUT  = 2000000,
    parameter int RSP_WAIT = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [TX_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [RX_WIDTH-1:0] rsp_data,
    output logic [1:0]          rsp_err,
    output logic                busy,
    output logic                tx_rst,
    output logic                tx_start,
    output logic [TX_WIDTH-1:0] tx_data,
    output logic                rx_rst,
    output logic                rx_start,
    input  logic [RX_WIDTH-1:0] rx_data,
    input  logic                tx_full,
    input  logic                tx_empty,
    input  logic                rx_full,
    input  logic                rx_empty
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_LOAD, S_SEND, S_WAIT, S_DONE
    } state_t;

    localparam logic [23:0] TO_LAST = 24'(TIMEOUT - 1);
    localparam logic [23:0] RW_LAST = 24'(RSP_WAIT - 1);

    state_t              state_q, state_d;
    logic [23:0]         cnt_q, cnt_d;
    logic                seen_q, seen_d;
    logic [TX_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [RX_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]          err_q, err_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                clr_pulse_q, clr_pulse_d;
    logic                start_pulse_q, start_pulse_d;

    logic accept, send_exit, send_to, wait_end, rsp_hs;
    logic unused_ok;

    // Wrapper status bits that are observed but never steer the sequence.
    assign unused_ok = ^{tx_full, rx_empty};

    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign send_exit = seen_q && tx_empty;
    assign send_to   = (cnt_q == TO_LAST);
    assign wait_end  = (cnt_q == RW_LAST);
    assign rsp_hs    = rsp_valid_q && rsp_ready;

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = err_q;
    assign tx_data   = tx_data_q;
    assign tx_rst    = clr_pulse_q;
    assign rx_rst    = clr_pulse_q;
    assign tx_start  = start_pulse_q;
    assign rx_start  = start_pulse_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            seen_q        <= 1'b0;
            tx_data_q     <= '0;
            rsp_data_q    <= '0;
            err_q         <= '0;
            rsp_valid_q   <= 1'b0;
            clr_pulse_q   <= 1'b0;
            start_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            tx_data_q     <= tx_data_d;
            rsp_data_q    <= rsp_data_d;
            err_q         <= err_d;
            rsp_valid_q   <= rsp_valid_d;
            clr_pulse_q   <= clr_pulse_d;
            start_pulse_q <= start_pulse_d;
        end
    end

    // A completed send takes priority over a timeout on the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_CLR;
            S_CLR:  state_d = S_LOAD;
            S_LOAD: state_d = S_SEND;
            S_SEND: begin
                if (send_exit)    state_d = S_WAIT;
                else if (send_to) state_d = S_DONE;
            end
            S_WAIT: if (wait_end) state_d = S_DONE;
            S_DONE: if (rsp_hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pulses are registered one state early so they line up with CLR/LOAD.
    always_comb begin
        cnt_d         = cnt_q;
        seen_d        = seen_q;
        tx_data_d     = tx_data_q;
        rsp_data_d    = rsp_data_q;
        err_d         = err_q;
        rsp_valid_d   = rsp_valid_q;
        clr_pulse_d   = 1'b0;
        start_pulse_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    tx_data_d   = cmd_data;
                    err_d       = 2'b00;
                    clr_pulse_d = 1'b1;
                end
            end
            S_CLR: start_pulse_d = 1'b1;
            S_LOAD: begin
                cnt_d  = '0;
                seen_d = 1'b0;
            end
            S_SEND: begin
                cnt_d = cnt_q + 24'd1;
                if (!tx_empty) seen_d = 1'b1;
                if (send_exit) begin
                    cnt_d = '0;
                end else if (send_to) begin
                    err_d[0]    = 1'b1;
                    rsp_data_d  = '0;
                    rsp_valid_d = 1'b1;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 24'd1;
                if (rx_full) err_d[1] = 1'b1;
                if (wait_end) begin
                    rsp_data_d  = rx_data;
                    rsp_valid_d = 1'b1;
                end
            end
            S_DONE: if (rsp_hs) rsp_valid_d = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed + randomized bench for uart_cmd_sequencer with a reactive
// UART wrapper stub and a transaction-level expectation model.
module tb_uart_cmd_sequencer;

    localparam int TIMEOUT  = 100;
    localparam int RSP_WAIT = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_err;
    logic        busy;
    logic        tx_rst, tx_start, rx_rst, rx_start;
    logic [31:0] tx_data;
    logic [31:0] rx_data = '0;
    logic        tx_full = 1'b0;
    logic        tx_empty = 1'b1;
    logic        rx_full = 1'b0;
    logic        rx_empty = 1'b1;

    int checks = 0;
    int failures = 0;

    uart_cmd_sequencer #(
        .TX_WIDTH(32), .RX_WIDTH(32),
        .TIMEOUT(TIMEOUT), .RSP_WAIT(RSP_WAIT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .tx_rst(tx_rst), .tx_start(tx_start), .tx_data(tx_data),
        .rx_rst(rx_rst), .rx_start(rx_start), .rx_data(rx_data),
        .tx_full(tx_full), .tx_empty(tx_empty),
        .rx_full(rx_full), .rx_empty(rx_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_reset_values(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
        chk({tag, "_pulses"}, 32'({tx_rst, rx_rst, tx_start, rx_start}), 0);
    endtask

    // One command from offer to handshake. d = cycles the stub holds
    // tx_empty low after the start pulse (0 = never busy), ovf_w = WAIT_RSP
    // cycle index carrying an rx_full pulse (-1 = none), hold = cycles of
    // rsp_ready backpressure, rx_fix = constant rx word (0 = random per cycle).
    task automatic run_txn(input string tag, input logic [31:0] cmd,
                           input logic [31:0] rx_fix, input int d,
                           input int ovf_w, input int hold);
        bit          tmo;
        int          n, lat, t, t_valid, bad;
        int          pc[4], pt[4];
        logic [31:0] exp_data, held_data;
        logic [1:0]  exp_err, held_err;
        logic [3:0]  pl;

        tmo      = (d == 0) || (d + 1 > TIMEOUT);
        n        = tmo ? TIMEOUT : d + 1;
        lat      = tmo ? 3 + n : 3 + n + RSP_WAIT;
        exp_err  = {(!tmo && ovf_w >= 0), tmo};
        exp_data = '0;
        for (int i = 0; i < 4; i++) begin
            pc[i] = 0;
            pt[i] = -1;
        end

        tx_empty  = 1'b1;
        rx_full   = 1'b0;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_data  = cmd;
        chk({tag, "_cmd_ready_idle"}, 32'(cmd_ready), 1);

        t = 0;
        t_valid = -1;
        bad = 0;
        while (t_valid < 0 && t < lat + 50) begin
            @(negedge clk);
            t++;
            pl = {tx_rst, rx_rst, tx_start, rx_start};
            for (int i = 0; i < 4; i++) begin
                if (pl[i]) begin
                    pc[i]++;
                    pt[i] = t;
                end
            end
            if (rsp_valid) t_valid = t;
            else if (!busy || cmd_ready) bad++;
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_data  = $urandom;
            tx_full   = 1'($urandom_range(0, 1));
            rx_empty  = 1'($urandom_range(0, 1));
            tx_empty  = !(pt[1] > 0 && t > pt[1] && t <= pt[1] + d);
            if (t < 3 + n) rx_full = 1'($urandom_range(0, 1));
            else rx_full = (ovf_w >= 0 && t == 3 + n + ovf_w);
            rx_data = (rx_fix != 0) ? rx_fix : $urandom;
            if (!tmo && t == 3 + n + RSP_WAIT - 1) exp_data = rx_data;
        end

        chk({tag, "_latency"}, 32'(t_valid), 32'(lat));
        chk({tag, "_busy_during"}, 32'(bad), 0);
        chk({tag, "_rst_pulses"}, 32'(pc[3] + pc[2]), 2);
        chk({tag, "_rst_cycle"}, 32'(pt[3] * 16 + pt[2]), 32'(1 * 16 + 1));
        chk({tag, "_start_pulses"}, 32'(pc[1] + pc[0]), 2);
        chk({tag, "_start_cycle"}, 32'(pt[1] * 16 + pt[0]), 32'(2 * 16 + 2));
        chk({tag, "_tx_data"}, tx_data, cmd);
        chk({tag, "_rsp_data"}, rsp_data, exp_data);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));

        held_data = rsp_data;
        held_err  = rsp_err;
        bad = 0;
        tx_empty  = 1'b1;
        rx_full   = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            cmd_data = $urandom;
            rx_data  = $urandom;
            rx_full  = 1'($urandom_range(0, 1));
            if (!rsp_valid || cmd_ready || rsp_data !== held_data ||
                rsp_err !== held_err || tx_data !== cmd) bad++;
        end
        chk({tag, "_hold_stable"}, 32'(bad), 0);

        rsp_ready = 1'b1;
        rx_full   = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_after_hs_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_after_hs_ready"}, 32'({busy, cmd_ready}), 32'b01);
    endtask

    task automatic reset_mid_send();
        int bad;
        tx_empty  = 1'b1;
        rx_full   = 1'b0;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_data  = $urandom;
        for (int t = 1; t <= 7; t++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            tx_empty  = !(t >= 3);
        end
        // cycle 7 is the fifth SEND cycle
        rst = 1'b1;
        @(negedge clk);
        chk_idle_reset_values("rst_send");
        chk("rst_send_cmd_ready_in_rst", 32'(cmd_ready), 0);
        rst = 1'b0;
        tx_empty = 1'b1;
        @(negedge clk);
        chk("rst_send_cmd_ready_after", 32'(cmd_ready), 1);
        bad = 0;
        repeat (RSP_WAIT + 10) begin
            @(negedge clk);
            if (rsp_valid || busy) bad++;
        end
        chk("rst_send_no_rsp", 32'(bad), 0);
    endtask

    initial begin
        int d, ovf, hold;
        repeat (3) @(negedge clk);
        chk_idle_reset_values("reset");
        chk("reset_cmd_ready_in_rst", 32'(cmd_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_cmd_ready_after", 32'(cmd_ready), 1);

        run_txn("nominal", 32'hDEADBEEF, 32'h12345678, 10, -1, 0);
        run_txn("timeout", $urandom, 0, 0, -1, 0);
        run_txn("overflow", $urandom, 0, 5, 7, 0);
        run_txn("ovf_last", $urandom, 0, 2, RSP_WAIT - 1, 1);
        run_txn("backpress", $urandom, 0, 3, -1, 15);
        run_txn("min_send", $urandom, 0, 1, 0, 0);
        run_txn("exit_at_limit", $urandom, 0, TIMEOUT - 1, -1, 2);
        run_txn("tmo_busy", $urandom, 0, TIMEOUT, 4, 0);

        reset_mid_send();
        run_txn("post_reset", 32'hDEADBEEF, 32'h12345678, 10, -1, 0);

        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 3) == 0) d = int'($urandom_range(95, 110));
            else d = int'($urandom_range(0, 30));
            if ($urandom_range(0, 1) == 0) ovf = -1;
            else ovf = int'($urandom_range(0, RSP_WAIT - 1));
            hold = int'($urandom_range(0, 5));
            run_txn("random", $urandom, 0, d, ovf, hold);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cmd_sequencer.md
UART_CMD_SEQUENCER -- requirements
Module: uart_cmd_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
TX_WIDTH, 32, command word width;
RX_WIDTH, 32, response word width;
TIMEOUT, 2000000, max cycles in SEND;
RSP_WAIT, 1000000, cycles in WAIT_RSP.
REQ-002 Ports SHALL be (name, direction, width, meaning):
clk, in, 1, single clock, rising edge;
rst, in, 1, synchronous active-high reset;
cmd_valid, in, 1, command offered;
cmd_ready, out, 1, command accepted when both high;
cmd_data, in, TX_WIDTH, command word;
rsp_valid, out, 1, response available;
rsp_ready, in, 1, response consumed when both high;
rsp_data, out, RX_WIDTH, captured response word;
rsp_err, out, 2, bit0 = tx timeout, bit1 = rx overflow;
busy, out, 1, state not IDLE;
tx_rst, out, 1, to UART wrapper;
tx_start, out, 1, to UART wrapper;
tx_data, out, TX_WIDTH, to UART wrapper;
rx_rst, out, 1, to UART wrapper;
rx_start, out, 1, to UART wrapper;
rx_data, in, RX_WIDTH, from UART wrapper;
tx_full, in, 1, from UART wrapper;
tx_empty, in, 1, from UART wrapper;
rx_full, in, 1, from UART wrapper;
rx_empty, in, 1, from UART wrapper.
REQ-003 The block SHALL use one clock (clk) and synchronous active-high reset (rst), with no other clock or asynchronous input.

Function
REQ-004 The FSM SHALL have states IDLE, CLR, LOAD, SEND, WAIT_RSP, DONE, one-hot or binary, all outputs registered except cmd_ready and busy (decoded from state).
REQ-005 In IDLE, cmd_ready SHALL be 1; cmd_valid&&cmd_ready SHALL latch cmd_data into tx_data, clear rsp_err, and go to CLR next cycle.
REQ-006 In CLR (exactly 1 cycle), tx_rst=1 and rx_rst=1 SHALL be driven; the next state is LOAD.
REQ-007 In LOAD (exactly 1 cycle), tx_start=1 and rx_start=1 SHALL be driven; the 24-bit cycle counter and the seen_busy flag SHALL be cleared; the next state is SEND.
REQ-008 In SEND: counter +1 per cycle; seen_busy is set when tx_empty==0; exit to WAIT_RSP (counter cleared) on the first cycle with seen_busy==1 and tx_empty==1.
REQ-009 In SEND, when counter==TIMEOUT-1 without that exit, the FSM SHALL go to DONE with rsp_err[0]=1 and rsp_data=0.
REQ-010 In WAIT_RSP: counter +1 per cycle; any cycle with rx_full==1 sets rsp_err[1] (sticky until next accept).
REQ-011 In WAIT_RSP, at counter==RSP_WAIT-1, rsp_data SHALL capture rx_data and the FSM SHALL move to DONE.
REQ-012 In DONE, rsp_valid=1 and rsp_data/rsp_err SHALL hold stable until rsp_valid&&rsp_ready, then go to IDLE with rsp_valid=0 the following cycle.
REQ-013 Latency from accept to rsp_valid SHALL be 3 + (SEND cycles) + RSP_WAIT cycles.
REQ-014 The timeout and overflow conditions SHALL be reported simultaneously if both occur; cmd_valid SHALL be ignored outside IDLE; tx_full SHALL be observed only (no effect on the FSM).
REQ-015 tx_rst, rx_rst, tx_start, and rx_start SHALL each be single-cycle pulses, never asserted together across CLR/LOAD boundaries.

Reset
REQ-016 While rst==1 at a clk edge: state=IDLE, tx_data=0, rsp_data=0, rsp_err=0, rsp_valid=0, all pulse outputs=0, counter=0, seen_busy=0.
REQ-017 cmd_ready SHALL be 0 during any cycle in which rst is high, and 1 on the first cycle after rst falls.
REQ-018 Reset asserted in any state (including mid-SEND or DONE) SHALL abort the transaction without emitting rsp_valid.

Verification (TIMEOUT=100, RSP_WAIT=20, wrapper stub)
REQ-019 Nominal: cmd_data=0xDEADBEEF; stub drops tx_empty for 10 cycles, then rx_data=0x12345678 -> tx_data=0xDEADBEEF, single pulses in CLR/LOAD, rsp_valid after 3+11+20 cycles, rsp_data=0x12345678, rsp_err=0.
REQ-020 Timeout: tx_empty held 1 forever -> rsp_valid at cycle 3+100, rsp_err=2'b01, rsp_data=0.
REQ-021 Overflow: rx_full pulsed 1 cycle mid WAIT_RSP -> rsp_err=2'b10, rsp_data=rx_data at the final WAIT_RSP cycle.
REQ-022 Backpressure: rsp_ready=0 for 15 cycles in DONE with cmd_valid=1 throughout -> rsp_valid/rsp_data stable, cmd_ready=0, no new accept until the cycle after the handshake.
REQ-023 Reset mid-SEND (cycle 5 of SEND) -> next cycle IDLE, all outputs at reset values, no rsp_valid, and the next command completes normally.
